// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage, requester side of the instruction-memory interface.
// Owns the PC, presents it to a zero-latency combinational instruction ROM and
// captures the returned word into the IF/ID pipeline register. Handles hazard
// stalls, IF/ID flushes and branch/jump redirects. A redirect that arrives
// while the stage is stalled is buffered and applied on the first unstalled
// cycle.
//
// Optional feature (macro FETCH_ADEL_EN): fetch address error detection.
// When defined, a fetch from a misaligned PC or from beyond the ROM is loaded
// into IF/ID as a NOP with id_exc set. When undefined, id_exc is tied to 0 and
// the ROM word is loaded unmodified.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   synchronous active-high reset
//   stall          in   hold PC and IF/ID
//   flush          in   clear IF/ID to a bubble
//   redirect_en    in   branch/jump taken this cycle
//   redirect_pc    in   [31:0] redirect target
//   im_pc          out  [31:0] ROM address (ROM indexes im_pc>>2)
//   im_instr       in   [31:0] ROM data, combinational from im_pc
//   id_instr       out  [31:0] IF/ID instruction
//   id_pc          out  [31:0] IF/ID PC of id_instr
//   id_pc8         out  [31:0] id_pc + 8 (link address)
//   id_valid       out  IF/ID holds a real instruction
//   id_exc         out  IF/ID fetch raised an address error
//   fetch_cnt      out  [31:0] instructions loaded into IF/ID
//   redirect_pend  out  a redirect is buffered
// ----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic [31:0] im_pc,
    input  logic [31:0] im_instr,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc8,
    output logic        id_valid,
    output logic        id_exc,
    output logic [31:0] fetch_cnt,
    output logic        redirect_pend
);

    // The ROM must hold at least one word and its byte range must fit in 32 bits.
    if (IM_WORDS < 1 || IM_WORDS > 32'h3FFF_FFFF) begin : g_bad_im_words
        $error("fetch_unit: IM_WORDS out of range");
    end

    logic [31:0] pc_q, pc_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic        id_valid_q, id_valid_d;
    logic        id_exc_q, id_exc_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic        fetch_bad;

`ifdef FETCH_ADEL_EN
    // Byte size of the ROM, widened so the comparison cannot overflow.
    localparam logic [32:0] IM_BYTES = 33'(IM_WORDS) * 33'd4;
    assign fetch_bad = (pc_q[1:0] != 2'b00) || ({1'b0, pc_q} >= IM_BYTES);
`else
    assign fetch_bad = 1'b0;
`endif

    // PC sequencing and redirect buffering.
    always_comb begin
        pc_d      = pc_q + 32'd4;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        if (stall) begin
            pc_d = pc_q;
            // The most recent redirect seen during a stall wins.
            if (redirect_en) begin
                pend_d    = 1'b1;
                pend_pc_d = redirect_pc;
            end
        end else if (redirect_en) begin
            // A fresh redirect supersedes anything buffered.
            pc_d   = redirect_pc;
            pend_d = 1'b0;
        end else if (pend_q) begin
            pc_d   = pend_pc_q;
            pend_d = 1'b0;
        end
    end

    // IF/ID register update; flush takes precedence over stall.
    always_comb begin
        id_instr_d  = id_instr_q;
        id_pc_d     = id_pc_q;
        id_valid_d  = id_valid_q;
        id_exc_d    = id_exc_q;
        fetch_cnt_d = fetch_cnt_q;
        if (flush) begin
            id_instr_d = 32'h0;
            id_pc_d    = pc_q;
            id_valid_d = 1'b0;
            id_exc_d   = 1'b0;
        end else if (!stall) begin
            id_instr_d  = fetch_bad ? 32'h0 : im_instr;
            id_pc_d     = pc_q;
            id_valid_d  = 1'b1;
            id_exc_d    = fetch_bad;
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            pend_q      <= 1'b0;
            pend_pc_q   <= 32'h0;
            id_instr_q  <= 32'h0;
            id_pc_q     <= 32'h0;
            id_valid_q  <= 1'b0;
            id_exc_q    <= 1'b0;
            fetch_cnt_q <= 32'h0;
        end else begin
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            pend_pc_q   <= pend_pc_d;
            id_instr_q  <= id_instr_d;
            id_pc_q     <= id_pc_d;
            id_valid_q  <= id_valid_d;
            id_exc_q    <= id_exc_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign im_pc         = pc_q;
    assign id_instr      = id_instr_q;
    assign id_pc         = id_pc_q;
    assign id_pc8        = id_pc_q + 32'd8;
    assign id_valid      = id_valid_q;
    assign id_exc        = id_exc_q;
    assign fetch_cnt     = fetch_cnt_q;
    assign redirect_pend = pend_q;

endmodule
